rr_octal_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- Sits in front of the octal-to-binary encode path. It turns an 8-bit request vector into a registered one-hot grant plus the matching 3-bit binary grant index.
- A hold timer bounds how long any requester can own the resource, so no requester starves.

---
 rtl/rr_octal_arbiter.sv | 109 ++++++++++
 tb/tb_rr_octal_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rr_octal_arbiter.sv
// Round-robin arbiter for eight requesters sharing one resource.
// Registered one-hot grant plus binary index; a hold timer forces release so no requester starves.
module rr_octal_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0]       gnt_reg, gnt_next;
  logic [2:0]       gnt_id_reg, gnt_id_next;
  logic             timeout_reg, timeout_next;

  logic [7:0] req_rot;
  logic [2:0] sel_off;
  logic [2:0] sel;

  // Rotate req so that bit 0 of req_rot is the requester at ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      logic [2:0] idx;
      assign idx        = ptr_reg + 3'(gi);
      assign req_rot[gi] = req[idx];
    end
  endgenerate

  // Lowest set bit of the rotated vector wins; descending scan keeps the last hit.
  always_comb begin
    sel_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) sel_off = 3'(i);
    end
  end

  assign sel = ptr_reg + sel_off;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next      = 8'd1 << sel;
          gnt_id_next   = sel;
          hold_cnt_next = '0;
          ptr_next      = sel + 3'd1;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_id_reg]) begin
          gnt_next    = 8'd0;
          gnt_id_next = 3'd0;
          state_next  = IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          gnt_next     = 8'd0;
          gnt_id_next  = 3'd0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 3'd0;
      hold_cnt_reg <= '0;
      gnt_reg      <= 8'd0;
      gnt_id_reg   <= 3'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = |gnt_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_octal_arbiter.sv
// Directed bench for rr_octal_arbiter: a cycle table for the default instance plus
// hand sequences for the hold timeout, async reset and a MAX_HOLD=3 rotation instance.
module tb_rr_octal_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  logic [7:0] req3 = 8'h00;
  logic [7:0] gnt3;
  logic [2:0] gnt_id3;
  logic       gnt_valid3;
  logic       timeout3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_octal_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_octal_arbiter #(.MAX_HOLD(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3),
    .gnt(gnt3), .gnt_id(gnt_id3), .gnt_valid(gnt_valid3), .timeout(timeout3)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs {gnt, gnt_id, gnt_valid, timeout} of the default instance.
  function automatic logic [31:0] outs();
    return 32'({gnt, gnt_id, gnt_valid, timeout});
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] g, input logic [2:0] i,
                                       input logic v, input logic t);
    return 32'({g, i, v, t});
  endfunction

  initial begin
    int held;
    logic [7:0] eg;

    // Reset held low with all requests asserted: outputs stay idle.
    #1 rst_n = 1'b0;
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset_cyc%0d", c), outs(), pack(8'h00, 3'd0, 1'b0, 1'b0));
      $display("reset cycle %0d: gnt=%h id=%0d valid=%0d timeout=%0d", c, gnt, gnt_id, gnt_valid, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h00;

    // Cycle table: req driven before the edge, outputs expected after it.
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h04, 8'h04, 3'd2, 1'b1, 1'b0});  // single request, ptr -> 3
    vq.push_back('{8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
    vq.push_back('{8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
    vq.push_back('{8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});  // voluntary release
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h09, 8'h08, 3'd3, 1'b1, 1'b0});  // ptr=3 beats requester 0
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h20, 8'h20, 3'd5, 1'b1, 1'b0});  // ptr -> 6
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h03, 8'h01, 3'd0, 1'b1, 1'b0});  // wrap 6,7 -> 0
    vq.push_back('{8'h02, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h02, 8'h02, 3'd1, 1'b1, 1'b0});
    vq.push_back('{8'h02, 8'h02, 3'd1, 1'b1, 1'b0});
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h80, 8'h80, 3'd7, 1'b1, 1'b0});  // sel=7, ptr wraps to 0
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h81, 8'h01, 3'd0, 1'b1, 1'b0});
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h40, 8'h40, 3'd6, 1'b1, 1'b0});
    vq.push_back('{8'hC0, 8'h40, 3'd6, 1'b1, 1'b0});  // other requests ignored while held
    vq.push_back('{8'h80, 8'h00, 3'd0, 1'b0, 1'b0});
    vq.push_back('{8'h80, 8'h80, 3'd7, 1'b1, 1'b0});
    vq.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

    foreach (vq[k]) begin
      @(negedge clk);
      req = vq[k].req;
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), outs(), pack(vq[k].gnt, vq[k].id, vq[k].valid, vq[k].to));
      $display("vec %0d: req=%h gnt=%h id=%0d valid=%0d timeout=%0d", k, req, gnt, gnt_id, gnt_valid, timeout);
    end

    // Forced release after MAX_HOLD=15 cycles, then regrant of the sole requester.
    @(negedge clk);
    req = 8'h80;
    @(posedge clk); #1;
    check("timeout_first_grant", 32'(gnt), 32'h80);
    held = 1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (gnt != 8'h80) break;
      check("timeout_no_early_pulse", 32'(timeout), 32'd0);
      held++;
    end
    check("timeout_hold_len", 32'(held), 32'd15);
    check("timeout_pulse", outs(), pack(8'h00, 3'd0, 1'b0, 1'b1));
    $display("timeout: held=%0d gnt=%h timeout=%0d", held, gnt, timeout);
    @(posedge clk); #1;
    check("timeout_regrant", outs(), pack(8'h80, 3'd7, 1'b1, 1'b0));
    $display("regrant: gnt=%h id=%0d timeout=%0d", gnt, gnt_id, timeout);

    // Async reset while requester 4 holds the grant.
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    req = 8'h10;
    @(posedge clk); #1;
    check("areset_pre_grant", outs(), pack(8'h10, 3'd4, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("areset_immediate", outs(), pack(8'h00, 3'd0, 1'b0, 1'b0));
    $display("async reset: gnt=%h valid=%0d", gnt, gnt_valid);
    @(negedge clk);
    req = 8'h30;  // ptr restart at 0 picks 4 ahead of 5
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("areset_after", outs(), pack(8'h10, 3'd4, 1'b1, 1'b0));
    $display("after reset: gnt=%h id=%0d", gnt, gnt_id);
    @(negedge clk);
    req = 8'h00;

    // Rotation on the MAX_HOLD=3 instance with every requester asserted.
    @(negedge clk);
    req3 = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      eg = 8'd1 << (g % 8);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c < 3)
          check($sformatf("rot%0d_hold%0d", g, c),
                32'({gnt3, gnt_id3, gnt_valid3, timeout3}), pack(eg, 3'(g % 8), 1'b1, 1'b0));
        else
          check($sformatf("rot%0d_gap", g),
                32'({gnt3, gnt_id3, gnt_valid3, timeout3}), pack(8'h00, 3'd0, 1'b0, 1'b1));
      end
      $display("rotation grant %0d: requester %0d", g, g % 8);
    end
    req3 = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
